// File: rtl/rhs_rx_pkg.sv
// rtl/rhs_rx_pkg.sv - shared constants and state type for the RHS MISO receive path
//
// Purpose : common definitions imported by rhs_miso_deserializer and its
//           sub-module.
// Contents: RHS_WORD_BITS, RHS_NUM_MISO, RHS_DELAY_W, rhs_rx_state_t.
// Build   : optional macro RHS_MISO_SYNC_EN is consumed by the top, not here.

package rhs_rx_pkg;

  localparam int RHS_WORD_BITS = 32;
  localparam int RHS_NUM_MISO  = 16;
  localparam int RHS_DELAY_W   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    DRAIN   = 2'd2,
    WAIT_CS = 2'd3
  } rhs_rx_state_t;

endpackage

// File: rtl/rhs_edge_delay_line.sv
// rtl/rhs_edge_delay_line.sv - programmable delay for detected SCLK rises
//
// Purpose : shift register that delays each injected SCLK-rise marker by
//           `select` cycles, then fires a one-cycle sample strobe.
// Ports   : clk, rst_n     - clock, synchronous active-low reset
//           inject         - push a marker into tap 0 next cycle
//           clear          - flush all markers (wins over inject)
//           select         - tap that drives strobe
//           strobe         - marker present at the selected tap
//           empty          - no marker at or below the selected tap, i.e.
//                            no strobe can fire any more

module rhs_edge_delay_line #(
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inject,
  input  logic             clear,
  input  logic [SEL_W-1:0] select,
  output logic             strobe,
  output logic             empty
);

  localparam int DEPTH = 1 << SEL_W;

  logic [DEPTH-1:0] line;
  logic             pending;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      line <= '0;
    end else begin
      line <= {line[DEPTH-2:0], inject};
    end
  end

  assign strobe = line[select];

  // Markers that have already moved past the tap can never strobe again,
  // so only taps up to and including `select` count as pending.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i <= int'(select)) begin
        pending = pending | line[i];
      end
    end
  end

  assign empty = ~pending;

endmodule

// File: rtl/rhs_miso_deserializer.sv
// rtl/rhs_miso_deserializer.sv - 16-lane RHS MISO sampler and word assembler
//
// Purpose : samples all MISO lanes on each (cable-delay compensated) SCLK rise
//           during a CS frame, builds one 32-bit word per lane and offers the
//           frame downstream through a valid/ready holding register.
// Ports   : clk, rst_n         - clock, synchronous active-low reset
//           cs, sclk           - local copies of the master's CS (low) / SCLK
//           miso               - headstage MISO lanes, lane 0 = A
//           cable_delay        - sample delay after a detected SCLK rise
//           data_out           - lane k word at [32k+31:32k]
//           data_valid/ready   - holding-register handshake
//           busy               - receiver not idle
//           overflow           - sticky, a completed frame was dropped
//           short_frame_cnt    - saturating count of frames with < 32 samples
//           clear_status       - clears overflow and short_frame_cnt
// Build   : define RHS_MISO_SYNC_EN to put a 2-flop synchronizer in front of
//           miso_q (adds 2 cycles of sample latency).

module rhs_miso_deserializer
  import rhs_rx_pkg::*;
#(
  parameter int NUM_MISO  = RHS_NUM_MISO,
  parameter int WORD_BITS = RHS_WORD_BITS,
  parameter int DELAY_W   = RHS_DELAY_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cs,
  input  logic                          sclk,
  input  logic [NUM_MISO-1:0]           miso,
  input  logic [DELAY_W-1:0]            cable_delay,
  output logic [NUM_MISO*WORD_BITS-1:0] data_out,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic                          busy,
  output logic                          overflow,
  output logic [7:0]                    short_frame_cnt,
  input  logic                          clear_status
);

  rhs_rx_state_t state, state_d;

  logic                          cs_q, cs_qq, sclk_q, sclk_qq;
  logic [NUM_MISO-1:0]           miso_q;
  logic [DELAY_W-1:0]            delay_l;
  logic [5:0]                    bit_cnt;
  logic [NUM_MISO*WORD_BITS-1:0] sr, sr_next;

  logic sclk_rise, cs_fall;
  logic strobe, line_empty;
  logic frame_start, inject, line_clear, take_strobe, last_strobe;
  logic publish, short_evt, handshake, accept, drop;

  // ---------------------------------------------------------------- inputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_q    <= 1'b1;
      cs_qq   <= 1'b1;
      sclk_q  <= 1'b0;
      sclk_qq <= 1'b0;
    end else begin
      cs_q    <= cs;
      cs_qq   <= cs_q;
      sclk_q  <= sclk;
      sclk_qq <= sclk_q;
    end
  end

`ifdef RHS_MISO_SYNC_EN
  logic [NUM_MISO-1:0] miso_s1, miso_s2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      miso_s1 <= '0;
      miso_s2 <= '0;
      miso_q  <= '0;
    end else begin
      miso_s1 <= miso;
      miso_s2 <= miso_s1;
      miso_q  <= miso_s2;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      miso_q <= '0;
    end else begin
      miso_q <= miso;
    end
  end
`endif

  assign sclk_rise = sclk_q & ~sclk_qq;
  assign cs_fall   = cs_qq & ~cs_q;

  // ------------------------------------------------------------ delay line
  rhs_edge_delay_line #(
    .SEL_W (DELAY_W)
  ) u_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .inject (inject),
    .clear  (line_clear),
    .select (delay_l),
    .strobe (strobe),
    .empty  (line_empty)
  );

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (cs_fall) state_d = SHIFT;
      // A completed word beats a simultaneous CS rise.
      SHIFT:   if (last_strobe) state_d = WAIT_CS;
               else if (cs_q) state_d = DRAIN;
      DRAIN:   if (last_strobe || line_empty) state_d = IDLE;
      WAIT_CS: if (cs_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    frame_start = (state == IDLE) && cs_fall;
    inject      = (state == SHIFT) && !cs_q && sclk_rise;
    line_clear  = (state == IDLE) || (state == WAIT_CS);
    take_strobe = strobe && ((state == SHIFT) || (state == DRAIN));
    last_strobe = take_strobe && (bit_cnt == 6'(WORD_BITS - 1));
    publish     = last_strobe;
    short_evt   = (state == DRAIN) && line_empty && !last_strobe;
    busy        = (state != IDLE);
  end

  // -------------------------------------------------------------- datapath
  always_comb begin
    sr_next = sr;
    for (int k = 0; k < NUM_MISO; k++) begin
      sr_next[k*WORD_BITS +: WORD_BITS] =
        {sr[k*WORD_BITS +: WORD_BITS-1], miso_q[k]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr      <= '0;
      bit_cnt <= '0;
      delay_l <= '0;
    end else if (frame_start) begin
      sr      <= '0;
      bit_cnt <= '0;
      delay_l <= cable_delay;
    end else if (take_strobe) begin
      sr      <= sr_next;
      bit_cnt <= bit_cnt + 6'd1;
    end
  end

  // ------------------------------------------------------ holding register
  assign handshake = data_valid && data_ready;
  assign accept    = publish && (!data_valid || data_ready);
  assign drop      = publish && !accept;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out        <= '0;
      data_valid      <= 1'b0;
      overflow        <= 1'b0;
      short_frame_cnt <= '0;
    end else begin
      // The publish is taken from sr_next so the 32nd bit lands this cycle.
      if (accept) begin
        data_out   <= sr_next;
        data_valid <= 1'b1;
      end else if (handshake) begin
        data_valid <= 1'b0;
      end

      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_status) begin
        overflow <= 1'b0;
      end

      if (short_evt) begin
        if (clear_status) begin
          short_frame_cnt <= 8'd1;
        end else if (short_frame_cnt != 8'hFF) begin
          short_frame_cnt <= short_frame_cnt + 8'd1;
        end
      end else if (clear_status) begin
        short_frame_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rhs_miso_deserializer.sv
// tb/tb_rhs_miso_deserializer.sv - scoreboard bench for rhs_miso_deserializer

module tb_rhs_miso_deserializer;

  localparam int NL = 16;
  localparam int WB = 32;

  typedef logic [NL*WB-1:0] frame_t;

  logic        clk = 1'b0;
  logic        rst_n, cs, sclk, data_ready, clear_status;
  logic        data_valid, busy, overflow;
  logic [NL-1:0] miso, miso_src;
  logic [3:0]  cable_delay;
  frame_t      data_out;
  logic [7:0]  short_frame_cnt;

  logic [4:0]    tb_cdel;
  logic [NL-1:0] hist [16];

  int     n_cmp = 0;
  int     n_bad = 0;
  frame_t exp_q [$];

  always #5 clk = ~clk;

  rhs_miso_deserializer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cs              (cs),
    .sclk            (sclk),
    .miso            (miso),
    .cable_delay     (cable_delay),
    .data_out        (data_out),
    .data_valid      (data_valid),
    .data_ready      (data_ready),
    .busy            (busy),
    .overflow        (overflow),
    .short_frame_cnt (short_frame_cnt),
    .clear_status    (clear_status)
  );

  // Cable model: the pin sees miso_src delayed by tb_cdel clk cycles.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) hist[i] <= '0;
    end else begin
      for (int i = 15; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= miso_src;
    end
  end

  assign miso = (tb_cdel == 5'd0) ? miso_src : hist[4'(tb_cdel - 5'd1)];

  // Monitor: every accepted frame must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && data_valid && data_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL frame_unexpected: got %h required none", data_out);
      end else begin
        frame_t e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          n_bad++;
          $display("FAIL frame_data: got %h required %h", data_out, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic frame_t rand_frame();
    frame_t f;
    for (int k = 0; k < NL; k++) f[k*WB +: WB] = $urandom();
    return f;
  endfunction

  // Cable delay not compensated: every sample lands one bit late, the first
  // sample being the idle-low line.
  function automatic frame_t late_by_one(input frame_t f);
    frame_t r;
    for (int k = 0; k < NL; k++) r[k*WB +: WB] = f[k*WB +: WB] >> 1;
    return r;
  endfunction

  // One CS frame, SCLK = clk/4, MISO changes while SCLK is low.
  task automatic send_frame(input frame_t words, input int nbits, input bit cs_early,
                            input int abort_at, input bit chk_lat, input bit hs_last);
    cs   = 1'b0;
    sclk = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i == abort_at) begin
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_data_out", 32'(data_out != '0), 32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_short_cnt", 32'(short_frame_cnt), 32'd0);
        cs       = 1'b1;
        miso_src = '0;
        rst_n    = 1'b1;
        repeat (40) tick();
        return;
      end
      for (int k = 0; k < NL; k++) miso_src[k] = words[k*WB + (WB - 1 - i)];
      tick();
      tick();
      sclk = 1'b1;
      tick();
      if (cs_early && i == nbits - 1) cs = 1'b1;
      tick();
      sclk = 1'b0;
    end
    // Now two cycles after the last SCLK rise at the pin.
    if (chk_lat) begin
      @(negedge clk);
      check("valid_before_latency", 32'(data_valid), 32'd0);
      tick();
      @(negedge clk);
      check("valid_after_latency", 32'(data_valid), 32'd1);
    end
    if (hs_last) begin
      data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
    end
    cs       = 1'b1;
    miso_src = '0;
    repeat (40) tick();
  endtask

  initial begin
    frame_t f1, f3;
    int     budget;

    rst_n        = 1'b0;
    cs           = 1'b1;
    sclk         = 1'b0;
    miso_src     = '0;
    data_ready   = 1'b1;
    clear_status = 1'b0;
    cable_delay  = '0;
    tb_cdel      = '0;
    repeat (3) tick();
    check("reset_data_valid", 32'(data_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_short_cnt", 32'(short_frame_cnt), 32'd0);
    check("reset_data_out", 32'(data_out != '0), 32'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Nominal frame, lane A fixed pattern.
    f1 = rand_frame();
    f1[WB-1:0] = 32'hA5A5_0001;
    exp_q.push_back(f1);
    send_frame(f1, 32, 1'b0, -1, 1'b1, 1'b0);

    // Cable delay 6, compensated and not compensated.
    tb_cdel     = 5'd6;
    cable_delay = 4'd6;
    f1 = rand_frame();
    exp_q.push_back(f1);
    send_frame(f1, 32, 1'b0, -1, 1'b0, 1'b0);
    cable_delay = 4'd0;
    f1 = rand_frame();
    exp_q.push_back(late_by_one(f1));
    send_frame(f1, 32, 1'b0, -1, 1'b0, 1'b0);

    // Frame completes after CS rises.
    tb_cdel     = 5'd12;
    cable_delay = 4'd12;
    f1 = rand_frame();
    exp_q.push_back(f1);
    send_frame(f1, 32, 1'b1, -1, 1'b0, 1'b0);
    check("drain_short_cnt", 32'(short_frame_cnt), 32'd0);

    // Short frame: 20 edges only.
    tb_cdel     = 5'd0;
    cable_delay = 4'd0;
    send_frame(rand_frame(), 20, 1'b0, -1, 1'b0, 1'b0);
    check("short_cnt", 32'(short_frame_cnt), 32'd1);
    check("short_busy", 32'(busy), 32'd0);
    check("short_no_valid", 32'(data_valid), 32'd0);

    // Overflow: second frame is dropped, first retained.
    data_ready = 1'b0;
    f1 = rand_frame();
    exp_q.push_back(f1);
    send_frame(f1, 32, 1'b0, -1, 1'b0, 1'b0);
    send_frame(rand_frame(), 32, 1'b0, -1, 1'b0, 1'b0);
    check("ovf_valid_held", 32'(data_valid), 32'd1);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_data_kept", 32'(data_out == f1), 32'd1);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
    check("clear_short_cnt", 32'(short_frame_cnt), 32'd0);

    // Publish in the same cycle as the handshake of the pending frame.
    f3 = rand_frame();
    exp_q.push_back(f3);
    send_frame(f3, 32, 1'b0, -1, 1'b0, 1'b1);
    check("hs_pub_no_ovf", 32'(overflow), 32'd0);
    check("hs_pub_valid", 32'(data_valid), 32'd1);
    data_ready = 1'b1;
    tick();
    tick();

    // Randomized cable delays, compensated exactly.
    for (int n = 0; n < 5; n++) begin
      int c;
      c           = $urandom_range(0, 15);
      tb_cdel     = 5'(c);
      cable_delay = 4'(c);
      f1 = rand_frame();
      exp_q.push_back(f1);
      send_frame(f1, 32, 1'($urandom_range(0, 1)), -1, 1'b0, 1'b0);
    end
    check("random_no_short", 32'(short_frame_cnt), 32'd0);
    check("random_no_ovf", 32'(overflow), 32'd0);

    // Reset in the middle of a frame, then a clean frame.
    tb_cdel     = 5'd0;
    cable_delay = 4'd0;
    send_frame(rand_frame(), 32, 1'b0, 15, 1'b0, 1'b0);
    check("post_rst_short_cnt", 32'(short_frame_cnt), 32'd0);
    f1 = rand_frame();
    exp_q.push_back(f1);
    send_frame(f1, 32, 1'b0, -1, 1'b0, 1'b0);

    budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    check("all_frames_seen", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
